// File: rtl/cdrom_raspi_link.sv
// Link from the cdrom core to a Raspberry Pi byte source: a handshake FSM that
// requests bytes on RASPI_CLK / RASPI_ACK and buffers them in a show-ahead FIFO.
`timescale 1ns/1ps
module cdrom_raspi_link #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  input  logic [3:0]                    cmd_code,
  input  logic [11:0]                   cmd_len,
  output logic                          cmd_ready,
  input  logic                          fifo_re,
  output logic [7:0]                    fifo_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic [7:0]                    RASPI_DATA,
  input  logic                          RASPI_ACK,
  output logic [3:0]                    RASPI_CMD,
  output logic                          RASPI_EN,
  output logic                          RASPI_CLK
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = $clog2(SETUP_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_REL, S_WAIT_SPACE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         raspi_cmd_q, raspi_cmd_d;
  logic               raspi_en_q, raspi_en_d;
  logic               raspi_clk_q, raspi_clk_d;
  logic [11:0]        remaining_q, remaining_d;
  logic [SET_W-1:0]   setup_cnt_q, setup_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               ack_meta_q, ack_s_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop, full, tmo_hit;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = fifo_re && (count_q != '0);
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Handshake FSM; every exit to IDLE clears EN/CMD/CLK on the same edge
  always_comb begin
    state_d       = state_q;
    raspi_cmd_d   = raspi_cmd_q;
    raspi_en_d    = raspi_en_q;
    raspi_clk_d   = raspi_clk_q;
    remaining_d   = remaining_q;
    setup_cnt_d   = setup_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    push          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          raspi_cmd_d   = cmd_code;
          remaining_d   = cmd_len;
          timeout_err_d = 1'b0;
          raspi_en_d    = 1'b1;
          setup_cnt_d   = SET_W'(SETUP_CYCLES);
          state_d       = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q != '0) begin
          setup_cnt_d = setup_cnt_q - SET_W'(1);
        end else if (remaining_q == '0) begin
          state_d     = S_IDLE;
          raspi_en_d  = 1'b0;
          raspi_cmd_d = '0;
        end else if (full) begin
          state_d = S_WAIT_SPACE;
        end else begin
          state_d     = S_REQ;
          raspi_clk_d = 1'b1;
          tmo_cnt_d   = '0;
        end
      end
      S_REQ: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (ack_s_q) begin
          push        = 1'b1;
          remaining_d = remaining_q - 12'd1;
          raspi_clk_d = 1'b0;
          tmo_cnt_d   = '0;
          state_d     = S_REL;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          raspi_clk_d   = 1'b0;
          raspi_en_d    = 1'b0;
          raspi_cmd_d   = '0;
          state_d       = S_IDLE;
        end
      end
      S_REL: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (!ack_s_q) begin
          if (remaining_q == '0) begin
            state_d     = S_IDLE;
            raspi_en_d  = 1'b0;
            raspi_cmd_d = '0;
          end else if (full) begin
            state_d = S_WAIT_SPACE;
          end else begin
            state_d     = S_REQ;
            raspi_clk_d = 1'b1;
            tmo_cnt_d   = '0;
          end
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          raspi_clk_d   = 1'b0;
          raspi_en_d    = 1'b0;
          raspi_cmd_d   = '0;
          state_d       = S_IDLE;
        end
      end
      S_WAIT_SPACE: begin
        if (!full) begin
          state_d     = S_REQ;
          raspi_clk_d = 1'b1;
          tmo_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      raspi_cmd_q   <= '0;
      raspi_en_q    <= 1'b0;
      raspi_clk_q   <= 1'b0;
      remaining_q   <= '0;
      setup_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      ack_meta_q    <= 1'b0;
      ack_s_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      raspi_cmd_q   <= raspi_cmd_d;
      raspi_en_q    <= raspi_en_d;
      raspi_clk_q   <= raspi_clk_d;
      remaining_q   <= remaining_d;
      setup_cnt_q   <= setup_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      ack_meta_q    <= RASPI_ACK;
      ack_s_q       <= ack_meta_q;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: occupancy is governed by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= RASPI_DATA;
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign fifo_data   = mem_q[rd_ptr_q];
  assign fifo_empty  = (count_q == '0);
  assign fifo_count  = count_q;
  assign RASPI_CMD   = raspi_cmd_q;
  assign RASPI_EN    = raspi_en_q;
  assign RASPI_CLK   = raspi_clk_q;

endmodule

// File: tb/tb_cdrom_raspi_link.sv
// Bench for cdrom_raspi_link: a behavioural Pi responder feeds bytes, a queue of
// delivered bytes is the FIFO reference, and a monitor tallies EN/CLK activity.
`timescale 1ns/1ps
module tb_cdrom_raspi_link;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SETUP = 4;
  localparam int unsigned TMO   = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_code = '0;
  logic [11:0] cmd_len = '0;
  logic        cmd_ready;
  logic        fifo_re = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic [4:0]  fifo_count;
  logic        busy, timeout_err;
  logic [7:0]  raspi_data;
  logic        raspi_ack;
  logic [3:0]  raspi_cmd;
  logic        raspi_en, raspi_clk;

  logic        pi_mode = 1'b0;
  logic        man_ack = 1'b0;
  logic [7:0]  man_data = '0;
  logic        pi_ack;
  logic [7:0]  pi_data;
  int          pi_delay = 1;
  int          pi_limit = 0;
  int          pi_served = 0;
  logic [7:0]  pi_src[$];
  logic [7:0]  exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          tot_pulses = 0, tot_en = 0, tot_cmd_bad = 0, hi_run = 0, last_hi = 0;
  logic        prev_clk = 1'b0;
  logic [3:0]  exp_cmd = '0;

  assign raspi_ack  = pi_mode ? man_ack : pi_ack;
  assign raspi_data = pi_mode ? man_data : pi_data;

  always #5 clk = ~clk;

  cdrom_raspi_link #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .fifo_re(fifo_re), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err),
    .RASPI_DATA(raspi_data), .RASPI_ACK(raspi_ack), .RASPI_CMD(raspi_cmd),
    .RASPI_EN(raspi_en), .RASPI_CLK(raspi_clk)
  );

  // Pi responder: answers each CLK rise after pi_delay cycles, up to pi_limit bytes
  initial begin
    logic [7:0] b;
    pi_ack = 1'b0;
    pi_data = '0;
    forever begin
      @(negedge clk);
      if (!pi_mode && raspi_clk && !pi_ack && pi_served < pi_limit) begin
        repeat (pi_delay) @(negedge clk);
        if (!pi_mode && raspi_clk) begin
          if (pi_src.size() > 0) b = pi_src.pop_front();
          else b = 8'($urandom);
          pi_data = b;
          pi_ack = 1'b1;
          exp_q.push_back(b);
          pi_served++;
        end
      end else if (pi_ack && !raspi_clk) begin
        repeat (pi_delay) @(negedge clk);
        pi_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (raspi_en) begin
      tot_en++;
      if (raspi_cmd !== exp_cmd) tot_cmd_bad++;
    end
    if (raspi_clk) begin
      if (!prev_clk) tot_pulses++;
      hi_run++;
    end else if (prev_clk) begin
      last_hi = hi_run;
      hi_run = 0;
    end
    prev_clk = raspi_clk;
  end

  task automatic start_cmd(input logic [3:0] code, input logic [11:0] len);
    exp_cmd = code;
    cmd_code = code;
    cmd_len = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic pop_one(output logic [7:0] got);
    got = fifo_data;
    fifo_re = 1'b1;
    @(negedge clk);
    fifo_re = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({raspi_en, raspi_clk, raspi_cmd, fifo_empty, fifo_count, timeout_err} !== {1'b0, 1'b0, 4'h0, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_held en=%b clk=%b cmd=%h empty=%b count=%0d terr=%b", raspi_en, raspi_clk, raspi_cmd, fifo_empty, fifo_count, timeout_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic [7:0] want[3];
    logic [7:0] g;
    int p0, c0;
    bit ok;
    want[0] = 8'hA1; want[1] = 8'hB2; want[2] = 8'hC3;
    pi_src = '{8'hA1, 8'hB2, 8'hC3};
    pi_delay = 3;
    pi_limit = pi_served + 3;
    p0 = tot_pulses; c0 = tot_cmd_bad;
    start_cmd(4'd6, 12'd3);
    checks++;
    if ({busy, raspi_en, raspi_cmd} !== {1'b1, 1'b1, 4'd6}) begin
      errors++;
      $display("FAIL basic_start busy=%b en=%b cmd=%0d want 1 1 6", busy, raspi_en, raspi_cmd);
    end
    wait_idle(500, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done busy=%b want 0", busy); end
    checks++;
    if (tot_pulses - p0 != 3) begin errors++; $display("FAIL basic_pulses got %0d want 3", tot_pulses - p0); end
    checks++;
    if (tot_cmd_bad != c0) begin errors++; $display("FAIL basic_cmd_hold got %0d bad cycles want 0", tot_cmd_bad - c0); end
    checks++;
    if ({raspi_en, raspi_cmd, fifo_count} !== {1'b0, 4'd0, 5'd3}) begin
      errors++;
      $display("FAIL basic_end en=%b cmd=%0d count=%0d want 0 0 3", raspi_en, raspi_cmd, fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      pop_one(g);
      checks++;
      if (g !== want[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, g, want[i]); end
    end
    exp_q.delete();
    checks++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_zero_len;
    int p0, e0;
    bit ok;
    p0 = tot_pulses; e0 = tot_en;
    start_cmd(4'd9, 12'd0);
    wait_idle(100, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || tot_en - e0 != int'(SETUP) + 1) begin
      errors++;
      $display("FAIL zero_en_cycles got %0d want %0d", tot_en - e0, SETUP + 1);
    end
    checks++;
    if (tot_pulses != p0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL zero_no_clk pulses=%0d empty=%b want 0 1", tot_pulses - p0, fifo_empty);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] g, w;
    int n, bad, s0, popped;
    bit ok;
    pi_delay = 1;
    s0 = pi_served;
    pi_limit = pi_served + 20;
    start_cmd(4'h3, 12'd20);
    n = 0;
    while (fifo_count !== 5'd16 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (fifo_count !== 5'd16) begin errors++; $display("FAIL bp_fill count=%0d want 16", fifo_count); end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (raspi_clk !== 1'b0 || busy !== 1'b1 || fifo_count !== 5'd16) bad++;
    end
    checks++;
    if (bad != 0 || pi_served - s0 != 16) begin
      errors++;
      $display("FAIL bp_stall bad_cycles=%0d served=%0d want 0 16", bad, pi_served - s0);
    end
    popped = 0;
    for (int i = 0; i < 4; i++) begin
      pop_one(g);
      w = exp_q.pop_front();
      popped++;
      checks++;
      if (g !== w) begin errors++; $display("FAIL bp_pop%0d got %h want %h", i, g, w); end
    end
    wait_idle(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok || fifo_count !== 5'd16) begin errors++; $display("FAIL bp_resume busy=%b count=%0d want 0 16", busy, fifo_count); end
    n = 0;
    while (!fifo_empty && n < 40) begin
      pop_one(g);
      w = (exp_q.size() > 0) ? exp_q.pop_front() : ~g;
      popped++;
      n++;
      checks++;
      if (g !== w) begin errors++; $display("FAIL bp_drain%0d got %h want %h", n, g, w); end
    end
    checks++;
    if (popped != 20 || exp_q.size() != 0) begin errors++; $display("FAIL bp_total popped=%0d want 20", popped); end
  endtask

  task automatic test_timeout;
    logic [7:0] g, w;
    bit ok;
    pi_delay = 2;
    pi_limit = pi_served + 2;
    start_cmd(4'd5, 12'd5);
    wait_idle(1000, ok);
    @(negedge clk);
    checks++;
    if (!ok || {timeout_err, raspi_en, raspi_clk, raspi_cmd, fifo_count} !== {1'b1, 1'b0, 1'b0, 4'd0, 5'd2}) begin
      errors++;
      $display("FAIL tmo_abort terr=%b en=%b clk=%b cmd=%0d count=%0d want 1 0 0 0 2", timeout_err, raspi_en, raspi_clk, raspi_cmd, fifo_count);
    end
    checks++;
    if (last_hi != int'(TMO)) begin errors++; $display("FAIL tmo_length got %0d want %0d", last_hi, TMO); end
    for (int i = 0; i < 2; i++) begin
      pop_one(g);
      w = exp_q.pop_front();
      checks++;
      if (g !== w) begin errors++; $display("FAIL tmo_keep%0d got %h want %h", i, g, w); end
    end
    pi_limit = pi_served + 100;
    start_cmd(4'd1, 12'd0);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", timeout_err); end
    wait_idle(100, ok);
  endtask

  task automatic test_push_pop;
    logic [7:0] x, y, g;
    int n;
    bit ok;
    fifo_re = 1'b1;
    repeat (2) @(negedge clk);
    fifo_re = 1'b0;
    checks++;
    if ({fifo_empty, fifo_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL empty_pop count=%0d want 0", fifo_count); end
    pi_delay = 1;
    pi_limit = pi_served + 1;
    start_cmd(4'd2, 12'd1);
    wait_idle(200, ok);
    @(negedge clk);
    x = exp_q.pop_front();
    y = ~x;
    pi_mode = 1'b1;
    man_ack = 1'b0;
    start_cmd(4'd7, 12'd1);
    n = 0;
    while (raspi_clk !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    man_data = y;
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({fifo_count, fifo_data} !== {5'd1, x}) begin errors++; $display("FAIL pp_before count=%0d head=%h want 1 %h", fifo_count, fifo_data, x); end
    fifo_re = 1'b1;
    @(negedge clk);
    fifo_re = 1'b0;
    checks++;
    if ({fifo_count, fifo_data} !== {5'd1, y}) begin errors++; $display("FAIL pp_same_cycle count=%0d head=%h want 1 %h", fifo_count, fifo_data, y); end
    man_ack = 1'b0;
    wait_idle(200, ok);
    @(negedge clk);
    pi_mode = 1'b0;
    pop_one(g);
    checks++;
    if (!ok || g !== y || fifo_empty !== 1'b1) begin errors++; $display("FAIL pp_final got %h empty=%b want %h 1", g, fifo_empty, y); end
  endtask

  task automatic test_random;
    logic [7:0] w;
    logic [7:0] g;
    logic [11:0] len;
    int p0, c0, n;
    bit ok;
    for (int t = 0; t < 5; t++) begin
      len = 12'($urandom_range(1, 24));
      pi_delay = $urandom_range(0, 3);
      pi_limit = pi_served + int'(len);
      p0 = tot_pulses; c0 = tot_cmd_bad;
      start_cmd(4'($urandom_range(1, 15)), len);
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
        fifo_re = 1'b0;
        if (!fifo_empty && $urandom_range(0, 1) == 1) begin
          w = (exp_q.size() > 0) ? exp_q.pop_front() : ~fifo_data;
          checks++;
          if (fifo_data !== w) begin errors++; $display("FAIL rnd%0d_pop got %h want %h", t, fifo_data, w); end
          fifo_re = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      fifo_re = 1'b0;
      ok = (busy === 1'b0);
      @(negedge clk);
      checks++;
      if (!ok || tot_pulses - p0 != int'(len) || tot_cmd_bad != c0) begin
        errors++;
        $display("FAIL rnd%0d_txn busy=%b pulses=%0d want %0d cmd_bad=%0d", t, busy, tot_pulses - p0, len, tot_cmd_bad - c0);
      end
      checks++;
      if (int'(fifo_count) != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, fifo_count, exp_q.size()); end
      n = 0;
      while (!fifo_empty && n < 40) begin
        pop_one(g);
        w = (exp_q.size() > 0) ? exp_q.pop_front() : ~g;
        n++;
        checks++;
        if (g !== w) begin errors++; $display("FAIL rnd%0d_drain got %h want %h", t, g, w); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    pi_delay = 1;
    pi_limit = pi_served + 2;
    start_cmd(4'hC, 12'd5);
    n = 0;
    while (!(fifo_count === 5'd2 && raspi_clk === 1'b1) && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (raspi_clk !== 1'b1 || fifo_count !== 5'd2) begin errors++; $display("FAIL rstmid_reach clk=%b count=%0d want 1 2", raspi_clk, fifo_count); end
    rst = 1'b1;
    #1;
    checks++;
    if ({raspi_en, raspi_clk, raspi_cmd, busy, fifo_empty, fifo_count, timeout_err} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_abort en=%b clk=%b cmd=%0d busy=%b empty=%b count=%0d terr=%b", raspi_en, raspi_clk, raspi_cmd, busy, fifo_empty, fifo_count, timeout_err);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, fifo_empty} !== 2'b11) begin errors++; $display("FAIL rstmid_release ready=%b empty=%b want 1 1", cmd_ready, fifo_empty); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_timeout();
    test_push_pop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
